// File: rtl/hpdcache_plru_updt_queue_pkg.sv
// Shared types and defaults for the PLRU update queue.
// The cache configuration carries the set and way counts that size the queue.
package hpdcache_plru_updt_queue_pkg;

  typedef struct packed {
    int unsigned sets;
    int unsigned ways;
  } hpdcache_user_cfg_t;

  typedef struct packed {
    hpdcache_user_cfg_t u;
  } hpdcache_cfg_t;

  localparam hpdcache_cfg_t PLRU_Q_DEFAULT_CFG = '{u: '{sets: 32'd64, ways: 32'd4}};

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 32'd1);
  endfunction

endpackage

// File: rtl/hpdcache_plru_updt_queue_if.sv
// Request/response bundle between the cache pipeline and the PLRU update queue.
// The master drives hit/refill requests and flush; the slave is the queue.
interface hpdcache_plru_updt_queue_if
  import hpdcache_plru_updt_queue_pkg::*;
#(
  parameter int unsigned SW = $clog2(PLRU_Q_DEFAULT_CFG.u.sets),
  parameter int unsigned W  = PLRU_Q_DEFAULT_CFG.u.ways,
  parameter int unsigned OW = 3
);
  logic          flush_i;
  logic          hit_valid_i;
  logic          hit_ready_o;
  logic [SW-1:0] hit_set_i;
  logic [W-1:0]  hit_way_i;
  logic          refill_valid_i;
  logic [SW-1:0] refill_set_i;
  logic [W-1:0]  refill_way_i;
  logic          updt_o;
  logic [SW-1:0] updt_set_o;
  logic [W-1:0]  updt_way_o;
  logic          empty_o;
  logic [OW-1:0] occupancy_o;

  modport master (
    output flush_i, hit_valid_i, hit_set_i, hit_way_i,
           refill_valid_i, refill_set_i, refill_way_i,
    input  hit_ready_o, updt_o, updt_set_o, updt_way_o, empty_o, occupancy_o
  );

  modport slave (
    input  flush_i, hit_valid_i, hit_set_i, hit_way_i,
           refill_valid_i, refill_set_i, refill_way_i,
    output hit_ready_o, updt_o, updt_set_o, updt_way_o, empty_o, occupancy_o
  );
endinterface

// File: rtl/hpdcache_plru_updt_queue_chk.sv
// Simulation-only protocol checks for the PLRU update queue.
// Covers one-hot ways on both request sources and the output, and occupancy bound.
module hpdcache_plru_updt_queue_chk #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 4,
  parameter int unsigned OW    = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          hit_valid,
  input logic [W-1:0]  hit_way,
  input logic          refill_valid,
  input logic [W-1:0]  refill_way,
  input logic          updt,
  input logic [W-1:0]  updt_way,
  input logic [OW-1:0] occupancy
);
  hit_way_onehot: assert property (@(posedge clk) disable iff (rst) hit_valid |-> $onehot(hit_way));
  refill_way_onehot: assert property (@(posedge clk) disable iff (rst) refill_valid |-> $onehot(refill_way));
  updt_way_onehot: assert property (@(posedge clk) disable iff (rst) updt |-> $onehot(updt_way));
  occupancy_bound: assert property (@(posedge clk) disable iff (rst) occupancy <= OW'(DEPTH));
endmodule

// File: rtl/hpdcache_plru_updt_queue.sv
// Serialises PLRU updates from refills (never stalled, highest priority) and
// hits (queued, coalesced against the tail) into one registered update per cycle.
module hpdcache_plru_updt_queue
  import hpdcache_plru_updt_queue_pkg::*;
#(
  parameter hpdcache_cfg_t HPDcacheCfg = PLRU_Q_DEFAULT_CFG,
  parameter int unsigned   DEPTH       = 4
) (
  input logic clk_i,
  input logic rst_i,
  hpdcache_plru_updt_queue_if.slave bus
);
  localparam int unsigned SW = $clog2(HPDcacheCfg.u.sets);
  localparam int unsigned W  = HPDcacheCfg.u.ways;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = occ_width(DEPTH);

  typedef logic [SW-1:0] set_t;
  typedef logic [W-1:0]  way_vector_t;
  typedef struct packed {
    set_t        set;
    way_vector_t way;
  } entry_t;

  entry_t        mem_r [DEPTH];
  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [OW-1:0] occ_r;
  logic          ready_r;
  logic          empty_r;
  logic          updt_r;
  set_t          set_r;
  way_vector_t   way_r;

  entry_t        hit_s;
  entry_t        tail_entry_s;
  logic          fifo_empty_s;
  logic          hit_acc_s;
  logic          coalesce_s;
  logic          pop_s;
  logic          bypass_s;
  logic          push_s;
  logic          updt_nxt_s;
  logic [OW-1:0] occ_nxt_s;

  // Arbitration between refill, FIFO pop and hit bypass, plus next occupancy.
  always_comb begin
    hit_s.set    = bus.hit_set_i;
    hit_s.way    = bus.hit_way_i;
    tail_entry_s = mem_r[tail_r - PW'(1)];
    fifo_empty_s = (occ_r == '0);
    hit_acc_s    = bus.hit_valid_i & ready_r;
    // Coalescing compares against the tail as it stood before this cycle's pop.
    coalesce_s   = !fifo_empty_s && (hit_s == tail_entry_s);
    pop_s        = !bus.refill_valid_i && !fifo_empty_s && !bus.flush_i;
    bypass_s     = !bus.refill_valid_i && fifo_empty_s && hit_acc_s && !bus.flush_i;
    push_s       = hit_acc_s && !bus.flush_i && !bypass_s && !coalesce_s;
    updt_nxt_s   = bus.refill_valid_i | pop_s | bypass_s;
    occ_nxt_s    = occ_r;
    if (bus.flush_i) begin
      occ_nxt_s = '0;
    end else if (push_s && !pop_s) begin
      occ_nxt_s = occ_r + OW'(1);
    end else if (pop_s && !push_s) begin
      occ_nxt_s = occ_r - OW'(1);
    end else begin
      occ_nxt_s = occ_r;
    end
  end

  // FIFO storage, pointers and occupancy-derived status flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= '0;
      end
      head_r  <= '0;
      tail_r  <= '0;
      occ_r   <= '0;
      ready_r <= 1'b1;
      empty_r <= 1'b1;
    end else begin
      if (push_s) begin
        mem_r[tail_r] <= hit_s;
      end
      if (bus.flush_i) begin
        head_r <= '0;
        tail_r <= '0;
      end else begin
        if (push_s) tail_r <= tail_r + PW'(1);
        if (pop_s)  head_r <= head_r + PW'(1);
      end
      occ_r   <= occ_nxt_s;
      ready_r <= (occ_nxt_s < OW'(DEPTH));
      empty_r <= (occ_nxt_s == '0) && !updt_nxt_s;
    end
  end

  // Output register feeding the victim-selection block.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      updt_r <= 1'b0;
      set_r  <= '0;
      way_r  <= '0;
    end else if (bus.refill_valid_i) begin
      updt_r <= 1'b1;
      set_r  <= bus.refill_set_i;
      way_r  <= bus.refill_way_i;
    end else if (pop_s) begin
      updt_r <= 1'b1;
      set_r  <= mem_r[head_r].set;
      way_r  <= mem_r[head_r].way;
    end else if (bypass_s) begin
      updt_r <= 1'b1;
      set_r  <= hit_s.set;
      way_r  <= hit_s.way;
    end else begin
      updt_r <= 1'b0;
    end
  end

  assign bus.hit_ready_o = ready_r;
  assign bus.updt_o      = updt_r;
  assign bus.updt_set_o  = set_r;
  assign bus.updt_way_o  = way_r;
  assign bus.empty_o     = empty_r;
  assign bus.occupancy_o = occ_r;

endmodule

// File: tb/tb_hpdcache_plru_updt_queue.sv
// Directed and randomised bench for the PLRU update queue, checked every cycle
// against a queue-based reference model of the arbitration rules.
module tb_hpdcache_plru_updt_queue;
  import hpdcache_plru_updt_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned SW    = 6;
  localparam int unsigned W     = 4;
  localparam int unsigned OW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hpdcache_plru_updt_queue_if #(.SW(SW), .W(W), .OW(OW)) bus ();

  hpdcache_plru_updt_queue #(.HPDcacheCfg(PLRU_Q_DEFAULT_CFG), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  hpdcache_plru_updt_queue_chk #(.DEPTH(DEPTH), .W(W), .OW(OW)) chk (
    .clk(clk), .rst(rst),
    .hit_valid(bus.hit_valid_i), .hit_way(bus.hit_way_i),
    .refill_valid(bus.refill_valid_i), .refill_way(bus.refill_way_i),
    .updt(bus.updt_o), .updt_way(bus.updt_way_o), .occupancy(bus.occupancy_o)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [SW+W-1:0] q[$];
  logic            m_updt = 1'b0;
  logic [SW-1:0]   m_set  = '0;
  logic [W-1:0]    m_way  = '0;
  bit              last_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.flush_i        = 1'b0;
    bus.hit_valid_i    = 1'b0;
    bus.hit_set_i      = '0;
    bus.hit_way_i      = '0;
    bus.refill_valid_i = 1'b0;
    bus.refill_set_i   = '0;
    bus.refill_way_i   = '0;
  endtask

  task automatic hit(input int s, input logic [W-1:0] w);
    bus.hit_valid_i = 1'b1;
    bus.hit_set_i   = SW'(s);
    bus.hit_way_i   = w;
  endtask

  task automatic refill(input int s, input logic [W-1:0] w);
    bus.refill_valid_i = 1'b1;
    bus.refill_set_i   = SW'(s);
    bus.refill_way_i   = w;
  endtask

  // Advance one cycle: update the model from the driven inputs, then compare.
  task automatic step();
    int n;
    bit acc;
    bit byp;
    logic [SW+W-1:0] he;
    logic [SW+W-1:0] tl;
    n   = q.size();
    acc = bus.hit_valid_i && (n < int'(DEPTH));
    he  = {bus.hit_set_i, bus.hit_way_i};
    tl  = (n > 0) ? q[n-1] : '0;
    byp = 1'b0;
    if (bus.refill_valid_i) begin
      m_updt = 1'b1; m_set = bus.refill_set_i; m_way = bus.refill_way_i;
    end else if (n > 0 && !bus.flush_i) begin
      {m_set, m_way} = q.pop_front();
      m_updt = 1'b1;
    end else if (n == 0 && acc && !bus.flush_i) begin
      m_updt = 1'b1; m_set = bus.hit_set_i; m_way = bus.hit_way_i; byp = 1'b1;
    end else begin
      m_updt = 1'b0;
    end
    if (bus.flush_i) q.delete();
    else if (acc && !byp && !(n > 0 && he == tl)) q.push_back(he);
    last_acc = acc;
    @(posedge clk);
    #1;
    check("updt", 32'(bus.updt_o), 32'(m_updt));
    check("updt_set", 32'(bus.updt_set_o), 32'(m_set));
    check("updt_way", 32'(bus.updt_way_o), 32'(m_way));
    check("occupancy", 32'(bus.occupancy_o), 32'(q.size()));
    check("hit_ready", 32'(bus.hit_ready_o), 32'(q.size() < int'(DEPTH)));
    check("empty", 32'(bus.empty_o), 32'(q.size() == 0 && !m_updt));
  endtask

  initial begin
    int idx;
    int cnt;
    idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_updt", 32'(bus.updt_o), 32'd0);
    check("rst_set", 32'(bus.updt_set_o), 32'd0);
    check("rst_way", 32'(bus.updt_way_o), 32'd0);
    check("rst_occ", 32'(bus.occupancy_o), 32'd0);
    check("rst_empty", 32'(bus.empty_o), 32'd1);
    check("rst_ready", 32'(bus.hit_ready_o), 32'd1);

    // single bypassed hit
    hit(5, 4'b0010);
    step();
    check("bypass_set", 32'(bus.updt_set_o), 32'd5);
    check("bypass_way", 32'(bus.updt_way_o), 32'h2);
    check("bypass_occ", 32'(bus.occupancy_o), 32'd0);
    idle(); step();

    // refill and hit together
    refill(3, 4'b1000); hit(7, 4'b0001);
    step();
    check("rf_first_set", 32'(bus.updt_set_o), 32'd3);
    check("rf_occ1", 32'(bus.occupancy_o), 32'd1);
    idle(); step();
    check("rf_then_hit_set", 32'(bus.updt_set_o), 32'd7);
    check("rf_occ0", 32'(bus.occupancy_o), 32'd0);
    step();

    // refills hold off the pop while hits fill the FIFO
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      refill(30 + c, W'(1) << (c % 4));
      if (idx < 5) hit(10 + idx, W'(1) << (idx % 4)); else bus.hit_valid_i = 1'b0;
      step();
      if (last_acc) idx++;
    end
    check("acc_during_refill", 32'(idx), 32'd4);
    idle();
    for (int c = 0; c < 20 && idx < 5; c++) begin
      hit(10 + idx, W'(1) << (idx % 4));
      step();
      if (last_acc) idx++;
    end
    check("fifth_hit_accepted", 32'(idx), 32'd5);
    idle();
    repeat (8) step();

    // coalescing of identical consecutive hits
    cnt = 0;
    refill(40, 4'b0001); hit(1, 4'b0001); step();
    refill(41, 4'b0001); hit(9, 4'b0100); step();
    if (bus.updt_o && bus.updt_set_o == SW'(9)) cnt++;
    refill(42, 4'b0001); hit(9, 4'b0100); step();
    if (bus.updt_o && bus.updt_set_o == SW'(9)) cnt++;
    check("coalesce_occ", 32'(bus.occupancy_o), 32'd2);
    idle();
    for (int c = 0; c < 8; c++) begin
      step();
      if (bus.updt_o && bus.updt_set_o == SW'(9)) cnt++;
    end
    check("coalesce_count", 32'(cnt), 32'd1);

    // flush with queued entries and a simultaneous refill
    for (int c = 0; c < 3; c++) begin
      refill(50 + c, 4'b0010); hit(20 + c, 4'b1000); step();
    end
    check("pre_flush_occ", 32'(bus.occupancy_o), 32'd3);
    idle(); bus.flush_i = 1'b1; refill(2, 4'b0001); step();
    check("flush_occ", 32'(bus.occupancy_o), 32'd0);
    check("flush_set", 32'(bus.updt_set_o), 32'd2);
    idle();
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.updt_o) cnt++;
    end
    check("flush_no_leak", 32'(cnt), 32'd0);

    // randomised traffic with wrap-around
    for (int c = 0; c < 40 * int'(DEPTH); c++) begin
      idle();
      if ($urandom_range(99, 0) < 70) hit(int'($urandom_range(3, 0)), W'(1) << $urandom_range(3, 0));
      if ($urandom_range(99, 0) < 30) refill(int'($urandom_range(63, 0)), W'(1) << $urandom_range(3, 0));
      bus.flush_i = ($urandom_range(99, 0) < 3);
      step();
    end
    idle();
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
